// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes, selects, control vector.
// The MULTICYCLE_CONTROL_ADDI_EN macro adds addi to the set of legal opcodes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b01;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      OP_ADDI:                              op_legal = 1'b1;
`endif
      default:                              op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, datapath controls and debug state out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       illegal, instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal, instr_done, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal, instr_done, state
  );
endinterface

// File: rtl/multicycle_control_outputs.sv
// Combinational decode of controller state (+mem_ready, +opcode for the illegal pulse) into controls.
// ADDI states decode only when MULTICYCLE_CONTROL_ADDI_EN is defined.
module multicycle_outputs
  import multicycle_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        // Gate on ready so a stalled fetch never advances the PC.
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.ir_write  = i_mem_ready;
      end
      DECODE: begin
        o_ctrl.alu_src_b  = SRCB_IMM_SH2;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.illegal    = !op_legal(i_opcode);
        o_ctrl.instr_done = !op_legal(i_opcode);
      end
      MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_RTYPE;
      end
      R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle MIPS control FSM: state register + next-state logic; outputs decoded in multicycle_outputs.
// Define MULTICYCLE_CONTROL_ADDI_EN to add the ADDI_EXEC/ADDI_WB path for opcode 001000.
module multicycle_control
  import multicycle_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  multicycle_control_if.master ctl
);

  state_t r_state, w_next;
  logic   r_is_sw;
  ctrl_t  w_ctrl;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = FETCH;
      FETCH:     if (ctl.mem_ready) w_next = DECODE;
      DECODE: begin
        case (ctl.opcode)
          OP_RTYPE:     w_next = R_EXEC;
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          OP_ADDI:      w_next = ADDI_EXEC;
`endif
          default:      w_next = FETCH;
        endcase
      end
      MEM_ADDR:  w_next = r_is_sw ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (ctl.mem_ready) w_next = MEM_WB;
      MEM_WRITE: if (ctl.mem_ready) w_next = FETCH;
      R_EXEC:    w_next = R_WB;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ADDI_EXEC: w_next = ADDI_WB;
`endif
      default:   w_next = FETCH;
    endcase
  end

  // lw/sw choice is latched in DECODE so later opcode changes cannot redirect MEM_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_is_sw <= (ctl.opcode == OP_SW);
    end
  end

  multicycle_outputs u_outputs (
    .i_state     (r_state),
    .i_mem_ready (ctl.mem_ready),
    .i_opcode    (ctl.opcode),
    .o_ctrl      (w_ctrl)
  );

  assign ctl.pc_write      = w_ctrl.pc_write;
  assign ctl.pc_write_cond = w_ctrl.pc_write_cond;
  assign ctl.i_or_d        = w_ctrl.i_or_d;
  assign ctl.mem_read      = w_ctrl.mem_read;
  assign ctl.mem_write     = w_ctrl.mem_write;
  assign ctl.ir_write      = w_ctrl.ir_write;
  assign ctl.mem_to_reg    = w_ctrl.mem_to_reg;
  assign ctl.reg_write     = w_ctrl.reg_write;
  assign ctl.reg_dst       = w_ctrl.reg_dst;
  assign ctl.alu_src_a     = w_ctrl.alu_src_a;
  assign ctl.alu_src_b     = w_ctrl.alu_src_b;
  assign ctl.pc_source     = w_ctrl.pc_source;
  assign ctl.alu_op        = w_ctrl.alu_op;
  assign ctl.illegal       = w_ctrl.illegal;
  assign ctl.instr_done    = w_ctrl.instr_done;
  assign ctl.state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model, vector table, reset and random runs.
// Honors MULTICYCLE_CONTROL_ADDI_EN the same way as the design.
module tb_multicycle_control;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                         S_MEM_READ = 4'd4, S_MEM_WB = 4'd5, S_MEM_WRITE = 4'd6, S_R_EXEC = 4'd7,
                         S_R_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDI_EXEC = 4'd11,
                         S_ADDI_WB = 4'd12;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic       illegal, instr_done;
  } cv_t;

  typedef struct {
    logic [5:0] op;
    int fst, mst;            // stall cycles in fetch / in the memory access
    int ncyc, npcw, nmw, nill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if ctl();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .ctl(ctl));

  int checks = 0, failures = 0;
  logic [3:0] m_cur;
  int m_rest[$];
  logic o_done, o_pcw, o_mw, o_ill;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remaining states after DECODE for each opcode, packed as 4-bit codes; 0 = illegal.
  function automatic logic [11:0] route(input logic [5:0] op);
    case (op)
      6'b000000: route = {4'd0, S_R_WB, S_R_EXEC};
      6'b100011: route = {S_MEM_WB, S_MEM_READ, S_MEM_ADDR};
      6'b101011: route = {4'd0, S_MEM_WRITE, S_MEM_ADDR};
      6'b000100: route = {8'd0, S_BRANCH};
      6'b000010: route = {8'd0, S_JUMP};
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      6'b001000: route = {4'd0, S_ADDI_WB, S_ADDI_EXEC};
`endif
      default:   route = 12'd0;
    endcase
  endfunction

  function automatic cv_t exp_vec(input logic [3:0] s, input logic rdy, input logic [5:0] op);
    cv_t v = '0;
    case (s)
      S_FETCH:     begin v.mem_read = 1; v.alu_src_b = 2'b01; v.pc_write = rdy; v.ir_write = rdy; end
      S_DECODE:    begin v.alu_src_b = 2'b11; v.illegal = (route(op) == 0); v.instr_done = (route(op) == 0); end
      S_MEM_ADDR:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      S_MEM_READ:  begin v.mem_read = 1; v.i_or_d = 1; end
      S_MEM_WB:    begin v.reg_write = 1; v.mem_to_reg = 1; v.instr_done = 1; end
      S_MEM_WRITE: begin v.mem_write = 1; v.i_or_d = 1; v.instr_done = rdy; end
      S_R_EXEC:    begin v.alu_src_a = 1; v.alu_op = 2'b01; end
      S_R_WB:      begin v.reg_write = 1; v.reg_dst = 1; v.instr_done = 1; end
      S_BRANCH:    begin v.alu_src_a = 1; v.alu_op = 2'b10; v.pc_write_cond = 1; v.pc_source = 2'b01; v.instr_done = 1; end
      S_JUMP:      begin v.pc_write = 1; v.pc_source = 2'b10; v.instr_done = 1; end
      S_ADDI_EXEC: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      S_ADDI_WB:   begin v.reg_write = 1; v.instr_done = 1; end
      default:     v = '0;
    endcase
    return v;
  endfunction

  function automatic cv_t act_vec();
    return {ctl.pc_write, ctl.pc_write_cond, ctl.i_or_d, ctl.mem_read, ctl.mem_write, ctl.ir_write,
            ctl.mem_to_reg, ctl.reg_write, ctl.reg_dst, ctl.alu_src_a, ctl.alu_src_b, ctl.pc_source,
            ctl.alu_op, ctl.illegal, ctl.instr_done};
  endfunction

  task automatic m_step(input logic rdy, input logic [5:0] op);
    logic [11:0] r;
    if (m_cur == S_IDLE) m_cur = S_FETCH;
    else if ((m_cur == S_FETCH || m_cur == S_MEM_READ || m_cur == S_MEM_WRITE) && !rdy) m_cur = m_cur;
    else if (m_cur == S_FETCH) m_cur = S_DECODE;
    else begin
      if (m_cur == S_DECODE) begin
        r = route(op);
        for (int i = 0; i < 3; i++) if (r[i*4 +: 4] != 0) m_rest.push_back(int'(r[i*4 +: 4]));
      end
      m_cur = (m_rest.size() != 0) ? 4'(m_rest.pop_front()) : S_FETCH;
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at posedge.
  task automatic cyc(input logic [5:0] op, input logic rdy);
    cv_t a;
    ctl.opcode = op;
    ctl.mem_ready = rdy;
    @(negedge clk);
    a = act_vec();
    chk($sformatf("ctrl@state%0d", m_cur), 32'(a), 32'(exp_vec(m_cur, rdy, op)));
    chk("state", 32'(ctl.state), 32'(m_cur));
    o_done = a.instr_done; o_pcw = a.pc_write; o_mw = a.mem_write; o_ill = a.illegal;
    @(posedge clk);
    m_step(rdy, op);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0, fl = 0, ml = 0, pcw = 0, mw = 0, ill = 0;
    bit done = 0;
    logic r;
    logic [5:0] o;
    while (!done && n < 40) begin
      o = (m_cur == S_DECODE) ? v.op : 6'($urandom);
      r = 1'b1;
      if (m_cur == S_FETCH && fl < v.fst) begin r = 1'b0; fl++; end
      if ((m_cur == S_MEM_READ || m_cur == S_MEM_WRITE) && ml < v.mst) begin r = 1'b0; ml++; end
      cyc(o, r);
      n++;
      pcw += int'(o_pcw); mw += int'(o_mw); ill += int'(o_ill);
      done = o_done;
    end
    chk($sformatf("latency op=%b", v.op), 32'(n), 32'(v.ncyc));
    chk($sformatf("pc_write_pulses op=%b", v.op), 32'(pcw), 32'(v.npcw));
    chk($sformatf("mem_write_cycles op=%b", v.op), 32'(mw), 32'(v.nmw));
    chk($sformatf("illegal_pulses op=%b", v.op), 32'(ill), 32'(v.nill));
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000010;
      5: return 6'b001000;
      default: return 6'($urandom);
    endcase
  endfunction

  vec_t tv[11];

  initial begin
    tv[0]  = '{6'b100011, 0, 0, 5, 1, 0, 0};
    tv[1]  = '{6'b000000, 0, 0, 4, 1, 0, 0};
    tv[2]  = '{6'b000100, 0, 0, 3, 1, 0, 0};
    tv[3]  = '{6'b101011, 2, 3, 9, 1, 4, 0};
    tv[4]  = '{6'b000010, 0, 0, 3, 2, 0, 0};
    tv[5]  = '{6'b111111, 0, 0, 2, 1, 0, 1};
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    tv[6]  = '{6'b001000, 0, 0, 4, 1, 0, 0};
`else
    tv[6]  = '{6'b001000, 0, 0, 2, 1, 0, 1};
`endif
    tv[7]  = '{6'b100011, 1, 2, 8, 1, 0, 0};
    tv[8]  = '{6'b101011, 0, 0, 4, 1, 1, 0};
    tv[9]  = '{6'b100000, 0, 0, 2, 1, 0, 1};
    tv[10] = '{6'b000100, 3, 0, 6, 1, 0, 0};

    rst_n = 1'b0;
    ctl.opcode = 6'b000000;
    ctl.mem_ready = 1'b1;
    #1;
    chk("reset_ctrl", 32'(act_vec()), 32'd0);
    chk("reset_state", 32'(ctl.state), 32'(S_IDLE));
    @(posedge clk); #1;
    chk("reset_hold_state", 32'(ctl.state), 32'(S_IDLE));
    rst_n = 1'b1;
    m_cur = S_IDLE;
    cyc(6'b100011, 1'b1);

    foreach (tv[i]) run_vec(tv[i]);

    // Reset asserted mid-R_EXEC and held across three rising edges.
    cyc(6'b111000, 1'b1);
    cyc(6'b000000, 1'b1);
    chk("model_in_r_exec", 32'(ctl.state), 32'(S_R_EXEC));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 32'(act_vec()), 32'd0);
    chk("async_reset_state", 32'(ctl.state), 32'(S_IDLE));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_reset_ctrl", 32'(act_vec()), 32'd0);
      chk("held_reset_state", 32'(ctl.state), 32'(S_IDLE));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cur = S_IDLE;
    m_rest.delete();
    cyc(6'b000000, 1'b1);
    chk("post_reset_fetch", 32'(ctl.state), 32'(S_FETCH));
    chk("post_reset_mem_read", 32'(ctl.mem_read), 32'd1);
    chk("post_reset_alu_src_b", 32'(ctl.alu_src_b), 32'd1);

    // Random opcodes (DECODE only; junk elsewhere) and random mem_ready.
    begin
      int ninstr = 0, ncyc = 0;
      logic [5:0] cur_op = pick_op();
      while (ninstr < 150 && ncyc < 4000) begin
        cyc((m_cur == S_DECODE) ? cur_op : 6'($urandom), ($urandom_range(0, 3) != 0));
        ncyc++;
        if (o_done) begin ninstr++; cur_op = pick_op(); end
      end
      chk("random_instr_count", 32'(ninstr), 32'd150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
